// File: rtl/rv_alu_if.sv
// rv_alu_if: operand/result bundle between the execute-stage sequencer and the ALU.
//   master : drives in_valid, a, b, alu_op; observes the registered results
//   slave  : the ALU; consumes operands, drives alu_res, out_valid, zero, illegal_op
interface rv_alu_if;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_op;
    logic [31:0] alu_res;
    logic        out_valid;
    logic        zero;
    logic        illegal_op;

    modport master (
        output in_valid, a, b, alu_op,
        input  alu_res, out_valid, zero, illegal_op
    );

    modport slave (
        input  in_valid, a, b, alu_op,
        output alu_res, out_valid, zero, illegal_op
    );
endinterface

// File: rtl/rv_alu.sv
// rv_alu: 32-bit RV32I integer ALU with a single registered output stage.
//   clk  : rising-edge clock for all registers
//   rst  : asynchronous active-high reset (alu_res=0, zero=1, illegal_op=0, out_valid=0)
//   bus  : rv_alu_if.slave
//          in: in_valid, a, b, alu_op   out: alu_res, out_valid, zero, illegal_op
// Result appears exactly one cycle after an in_valid cycle; outputs hold while idle.
module rv_alu (
    input  logic       clk,
    input  logic       rst,
    rv_alu_if.slave    bus
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;

    logic [4:0]  shamt_s;
    logic [31:0] next_res_s;
    logic        next_illegal_s;

    logic [31:0] alu_res_r;
    logic        zero_r;
    logic        illegal_op_r;
    logic        out_valid_r;

    // Only the low five bits of b take part in shifts.
    assign shamt_s = bus.b[4:0];

    // Combinational operation select; unsupported codes yield zero plus the illegal flag.
    always_comb begin
        next_res_s     = 32'h0000_0000;
        next_illegal_s = 1'b0;
        case (bus.alu_op)
            OP_ADD:  next_res_s = bus.a + bus.b;
            OP_SUB:  next_res_s = bus.a - bus.b;
            OP_SLL:  next_res_s = bus.a << shamt_s;
            OP_SLT:  next_res_s = {31'd0, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: next_res_s = {31'd0, (bus.a < bus.b)};
            OP_XOR:  next_res_s = bus.a ^ bus.b;
            OP_SRL:  next_res_s = bus.a >> shamt_s;
            // Signed cast makes >>> replicate a[31] into the vacated bits.
            OP_SRA:  next_res_s = $unsigned($signed(bus.a) >>> shamt_s);
            OP_OR:   next_res_s = bus.a | bus.b;
            OP_AND:  next_res_s = bus.a & bus.b;
            default: begin
                next_res_s     = 32'h0000_0000;
                next_illegal_s = 1'b1;
            end
        endcase
    end

    // Output stage: capture on in_valid, hold data otherwise; out_valid is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_r    <= 32'h0000_0000;
            zero_r       <= 1'b1;
            illegal_op_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                alu_res_r    <= next_res_s;
                zero_r       <= (next_res_s == 32'h0000_0000);
                illegal_op_r <= next_illegal_s;
            end else begin
                alu_res_r    <= alu_res_r;
                zero_r       <= zero_r;
                illegal_op_r <= illegal_op_r;
            end
        end
    end

    assign bus.alu_res    = alu_res_r;
    assign bus.zero       = zero_r;
    assign bus.illegal_op = illegal_op_r;
    assign bus.out_valid  = out_valid_r;

endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: directed plus randomized checking of rv_alu against an arithmetic reference model.
module tb_rv_alu;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rv_alu_if bus ();

    rv_alu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected register contents, maintained by the bench.
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    logic        exp_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I semantics expressed with plain wide arithmetic.
    function automatic void ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic ill);
        int unsigned sh;
        longint      sx;
        longint      sy;
        sh  = y % 32;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ill = 1'b0;
        r   = 32'd0;
        case (op)
            5'd0:    r = 32'(64'(x) + 64'(y));
            5'd1:    r = 32'(64'(x) + 64'(~y) + 64'd1);
            5'd2:    r = 32'(64'(x) * (64'd1 << sh));
            5'd3:    r = (sx < sy) ? 32'd1 : 32'd0;
            5'd4:    r = (64'(x) < 64'(y)) ? 32'd1 : 32'd0;
            5'd5:    r = x ^ y;
            5'd6:    r = 32'(64'(x) / (64'd1 << sh));
            5'd7:    r = 32'(sx >>> sh);
            5'd8:    r = x | y;
            5'd9:    r = x & y;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".res"},   bus.alu_res,          exp_res);
        check({tag, ".zero"},  {31'd0, bus.zero},       {31'd0, exp_zero});
        check({tag, ".ill"},   {31'd0, bus.illegal_op}, {31'd0, exp_ill});
        check({tag, ".valid"}, {31'd0, bus.out_valid},  {31'd0, exp_valid});
    endtask

    // Called at a negedge: drive, let the posedge capture, check on the following negedge.
    task automatic step(input string tag, input logic v, input logic [4:0] op,
                        input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        il;
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk);
        exp_valid = v;
        if (v) begin
            ref_alu(op, x, y, r, il);
            exp_res  = r;
            exp_zero = (r == 32'd0);
            exp_ill  = il;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.alu_op   = 5'd0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        exp_res   = 32'd0;
        exp_zero  = 1'b1;
        exp_ill   = 1'b0;
        exp_valid = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, issued back-to-back.
        step("add",   1'b1, 5'd0, 32'h10, 32'h3);
        check("add_lit", bus.alu_res, 32'h0000_0013);
        step("sub",   1'b1, 5'd1, 32'h10, 32'h3);
        check("sub_lit", bus.alu_res, 32'h0000_000D);
        step("sll",   1'b1, 5'd2, 32'h10, 32'h3);
        check("sll_lit", bus.alu_res, 32'h0000_0080);
        step("xor",   1'b1, 5'd5, 32'h0F, 32'hF0);
        step("or",    1'b1, 5'd8, 32'h0F, 32'hF0);
        step("and",   1'b1, 5'd9, 32'h0F, 32'hF0);
        check("and_zero", {31'd0, bus.zero}, 32'd1);
        step("srl31", 1'b1, 5'd6, 32'h8000_0000, 32'h1F);
        check("srl31_lit", bus.alu_res, 32'h0000_0001);
        step("sra31", 1'b1, 5'd7, 32'h8000_0000, 32'h1F);
        check("sra31_lit", bus.alu_res, 32'hFFFF_FFFF);
        step("sra_hi", 1'b1, 5'd7, 32'h8000_0000, 32'hFFFF_FFE1);
        check("sra_hi_lit", bus.alu_res, 32'hC000_0000);
        step("srl_hi", 1'b1, 5'd6, 32'h8000_0000, 32'hFFFF_FFE1);
        step("sll0",  1'b1, 5'd2, 32'hDEAD_BEEF, 32'h20);
        step("sra0",  1'b1, 5'd7, 32'h8765_4321, 32'h0);
        step("slt_n", 1'b1, 5'd3, 32'hFFFF_FFFF, 32'h1);
        step("sltu_n",1'b1, 5'd4, 32'hFFFF_FFFF, 32'h1);
        step("sltu_p",1'b1, 5'd4, 32'h1, 32'hFFFF_FFFF);
        step("slt_p", 1'b1, 5'd3, 32'h1, 32'hFFFF_FFFF);
        step("slt_eq",1'b1, 5'd3, 32'h5, 32'h5);
        step("sub_eq",1'b1, 5'd1, 32'h1234_5678, 32'h1234_5678);
        step("add_ovf",1'b1, 5'd0, 32'hFFFF_FFFF, 32'h2);
        step("ill",   1'b1, 5'b10110, 32'h55, 32'h66);
        check("ill_flag", {31'd0, bus.illegal_op}, 32'd1);
        step("hold",  1'b0, 5'd0, 32'h1111_1111, 32'h2222_2222);
        step("ill_hi",1'b1, 5'b11111, 32'h1, 32'h1);
        step("ill_lo",1'b1, 5'b01010, 32'h1, 32'h1);
        step("add_b", 1'b1, 5'd0, 32'h7, 32'h9);
        step("hold2", 1'b0, 5'd1, 32'h0, 32'h0);

        // Mid-stream reset: capture an ADD, then pulse rst between edges.
        step("pre_rst", 1'b1, 5'd0, 32'h100, 32'h23);
        bus.in_valid = 1'b1;
        bus.alu_op   = 5'd0;
        bus.a        = 32'h4000;
        bus.b        = 32'h0001;
        @(posedge clk);
        #2 rst = 1'b1;
        exp_res   = 32'd0;
        exp_zero  = 1'b1;
        exp_ill   = 1'b0;
        exp_valid = 1'b0;
        #1 check_outputs("rst_mid");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_outputs("rst_after");
        step("post_rst", 1'b1, 5'd0, 32'h10, 32'h3);

        // Randomized traffic, biased toward legal opcodes and corner operands.
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  op;
            logic [31:0] x;
            logic [31:0] y;
            logic        v;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 7))
                0:       x = 32'h8000_0000;
                1:       y = x;
                2:       y = 32'hFFFF_FFFF;
                3:       x = 32'd0;
                default: ;
            endcase
            v = ($urandom_range(0, 4) != 0);
            step("rand", v, op, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
